reg_serial_tx: RTL and testbench

- Serial readout end of the parallel load-register path: captures an N-bit register value and shifts it out MSB-first on a 3-wire SPI-mode-0 style link (cs_n, sclk, sdo).
- Used to stream datapath register contents (accumulator, output register) to an external display or shift-register chain.
- Start/busy/done handshake on the fabric side; clock-divided serial timing on the pin side.

---
 rtl/reg_serial_tx_pkg.sv | 17 +
 rtl/reg_serial_tx_tick_div.sv | 25 ++
 rtl/reg_serial_tx.sv | 82 ++++++++
 tb/tb_reg_serial_tx.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/reg_serial_tx_pkg.sv
// reg_serial_tx_pkg: shared state encodings and sizing helper for the serial readout path
package reg_serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_serial_tx_tick_div.sv
// reg_serial_tx_tick_div: DIV-cycle counter, tick on the last cycle of each half-period
module reg_serial_tx_tick_div
    import reg_serial_tx_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int W = clog2(DIV) > 1 ? clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = run && cnt == W'(DIV - 1);

    always_ff @(posedge clk or posedge clr)
        if (clr)
            cnt <= '0;
        else
            cnt <= (!run || tick) ? '0 : cnt + W'(1);

endmodule

// File: rtl/reg_serial_tx.sv
// reg_serial_tx: captures an N-bit word and shifts it out MSB-first on cs_n/sclk/sdo
module reg_serial_tx
    import reg_serial_tx_pkg::*;
#(
    parameter int N   = 8,
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [N-1:0] d,
    output logic         busy,
    output logic         done,
    output logic         cs_n,
    output logic         sclk,
    output logic         sdo
);

    localparam int BW = clog2(N);

    state_t        state, state_n;
    logic [N-1:0]  sr, sr_n;
    logic [BW-1:0] bc, bc_n;
    logic          sclk_n, tick;

    reg_serial_tx_tick_div #(.DIV(DIV)) u_div (
        .clk  (clk),
        .clr  (clr),
        .run  (state != IDLE),
        .tick (tick)
    );

    // The final shift leaves sr all-zero, so sdo drops to 0 for HOLD and IDLE
    assign sdo  = sr[N-1];
    assign cs_n = ~busy;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        bc_n    = bc;
        sclk_n  = sclk;
        case (state)
            IDLE: if (start) begin
                state_n = SHIFT;
                sr_n    = d;
                bc_n    = '0;
                sclk_n  = 1'b0;
            end
            SHIFT: if (tick) begin
                sclk_n = ~sclk;
                if (sclk) begin
                    sr_n    = sr << 1;
                    bc_n    = bc == BW'(N - 1) ? bc : bc + BW'(1);
                    state_n = bc == BW'(N - 1) ? HOLD : SHIFT;
                end
            end
            HOLD: begin
                sclk_n  = 1'b0;
                state_n = tick ? IDLE : HOLD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            state <= IDLE;
            sr    <= '0;
            bc    <= '0;
            sclk  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            bc    <= bc_n;
            sclk  <= sclk_n;
            busy  <= state_n != IDLE;
            done  <= state == HOLD && tick;
        end

endmodule

// File: tb/tb_reg_serial_tx.sv
// tb_reg_serial_tx: randomized and directed frames checked every cycle against a frame-timing model
module tb_reg_serial_tx;

    localparam int L8 = 2 * 8 * 2 + 2;
    localparam int L4 = 2 * 4 * 1 + 1;

    logic clk = 1'b0, clr = 1'b1;
    logic s8 = 1'b0, s4 = 1'b0;
    logic [7:0] d8 = '0;
    logic [3:0] d4 = '0;
    logic b8, dn8, c8, k8, o8;
    logic b4, dn4, c4, k4, o4;

    int rem8 = 0, rem4 = 0;
    logic e8 = 1'b0, e4 = 1'b0;
    logic [7:0] w8 = '0;
    logic [3:0] w4 = '0;
    int mp8 = 0, mp4 = 0, np8 = 0, np4 = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    reg_serial_tx #(.N(8), .DIV(2)) dut8 (
        .clk(clk), .clr(clr), .start(s8), .d(d8),
        .busy(b8), .done(dn8), .cs_n(c8), .sclk(k8), .sdo(o8)
    );

    reg_serial_tx #(.N(4), .DIV(1)) dut4 (
        .clk(clk), .clr(clr), .start(s4), .d(d4),
        .busy(b4), .done(dn4), .cs_n(c4), .sclk(k4), .sdo(o4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pins expected k cycles into a frame of length 2*n*dv+dv: {busy,cs_n,sclk,sdo,done}
    function automatic logic [4:0] expv(input int rem, input int n, input int dv,
                                        input logic [7:0] w, input logic dn);
        int k;
        logic sc, sd;
        k  = 2 * n * dv + dv - rem;
        sc = k < 2 * n * dv && (k / dv) % 2 == 1;
        sd = k < 2 * n * dv ? w[n - 1 - k / (2 * dv)] : 1'b0;
        if (rem == 0)
            return {4'b0100, dn};
        return {2'b10, sc, sd, dn};
    endfunction

    always @(posedge clk or posedge clr)
        if (clr) begin
            rem8 <= 0; e8 <= 1'b0;
            rem4 <= 0; e4 <= 1'b0;
        end else begin
            e8 <= rem8 == 1;
            e4 <= rem4 == 1;
            if (rem8 == 1) mp8 <= mp8 + 1;
            if (rem4 == 1) mp4 <= mp4 + 1;
            if (rem8 == 0 && s8) begin rem8 <= L8; w8 <= d8; end
            else if (rem8 != 0) rem8 <= rem8 - 1;
            if (rem4 == 0 && s4) begin rem4 <= L4; w4 <= d4; end
            else if (rem4 != 0) rem4 <= rem4 - 1;
        end

    always @(negedge clk) begin
        check("pins8", 32'({b8, c8, k8, o8, dn8}), 32'(expv(rem8, 8, 2, w8, e8)));
        check("pins4", 32'({b4, c4, k4, o4, dn4}), 32'(expv(rem4, 4, 1, {4'b0, w4}, e4)));
        if (dn8) np8++;
        if (dn4) np4++;
    end

    task automatic wait8();
        int n = 0;
        while (rem8 != 0 && n < 200) begin @(negedge clk); n++; end
        check("timeout8", 32'(n < 200), 32'd1);
    endtask

    task automatic wait4();
        int n = 0;
        while (rem4 != 0 && n < 200) begin @(negedge clk); n++; end
        check("timeout4", 32'(n < 200), 32'd1);
    endtask

    task automatic send8(input logic [7:0] w);
        @(negedge clk);
        s8 = 1'b1; d8 = w;
        @(negedge clk);
        s8 = 1'b0; d8 = 8'($urandom);
    endtask

    initial begin
        s8 = 1'b1; d8 = 8'hA5;
        s4 = 1'b1; d4 = 4'b1001;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        s8 = 1'b0; s4 = 1'b0;
        wait8();
        wait4();

        send8(8'h3C);
        repeat (9) @(negedge clk);
        s8 = 1'b1; d8 = 8'hFF;
        @(negedge clk);
        s8 = 1'b0;
        wait8();
        repeat (10) @(negedge clk);

        send8(8'h81);
        wait8();
        s8 = 1'b1; d8 = 8'h7E;
        @(negedge clk);
        s8 = 1'b0; d8 = 8'h00;
        wait8();

        send8(8'hF0);
        repeat (11) @(negedge clk);
        #2 clr = 1'b1;
        #1 check("abort", 32'({b8, c8, k8, o8, dn8}), 32'(5'b01000));
        @(negedge clk);
        clr = 1'b0;
        send8(8'h0F);
        wait8();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 60)) begin
                @(negedge clk);
                s8 = ($urandom % 6) == 0; d8 = 8'($urandom);
                s4 = ($urandom % 4) == 0; d4 = 4'($urandom);
            end
        end
        s8 = 1'b0; s4 = 1'b0;
        wait8();
        wait4();
        repeat (3) @(negedge clk);
        check("pulses8", 32'(np8), 32'(mp8));
        check("pulses4", 32'(np4), 32'(mp4));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
